// File: rtl/ks_accum_16.sv
// rtl/ks_accum_16.sv - block accumulator built on a 16-bit Kogge-Stone adder
//
// kogge_stone_16bit : combinational 16-bit adder, S = Ai + Bi (17-bit result).
//
// ks_accum_16 : sums unsigned samples into blocks of up to BLOCK_LEN (1..256)
//    and presents each block sum on a valid/ready output port.
//    clk        - clock, rising edge
//    rst_n      - asynchronous active-low reset
//    clear      - synchronous abort of the current block, overrides handshakes
//    in_valid   - sample present on in_data
//    in_ready   - block accepting samples (state decode)
//    in_data    - 16-bit unsigned sample
//    in_last    - sample closes the block early
//    out_valid  - block result held on out_sum/out_ovf/out_count
//    out_ready  - consumer accepts the result
//    out_sum    - block sum
//    out_ovf    - at least one add in the block carried out of bit 15
//    out_count  - samples in the block, 1..BLOCK_LEN
//
// Build option KS_ACCUM_SATURATE_EN: a carrying add loads 16'hFFFF instead of
// the wrapped sum. out_ovf behaves the same in both builds.

module kogge_stone_16bit (
   input  logic [15:0] Ai,
   input  logic [15:0] Bi,
   output logic [16:0] S
);
   logic [15:0] g0, g1, g2, g3, g4;
   logic [15:0] p0, p1, p2, p3;

   assign g0 = Ai & Bi;
   assign p0 = Ai ^ Bi;

   // Prefix levels with span 1, 2, 4, 8. Shifting in ones for propagate keeps
   // the low bits (no partner at this span) unchanged.
   assign g1 = g0 | (p0 & (g0 << 1));
   assign p1 = p0 & ((p0 << 1) | 16'h0001);
   assign g2 = g1 | (p1 & (g1 << 2));
   assign p2 = p1 & ((p1 << 2) | 16'h0003);
   assign g3 = g2 | (p2 & (g2 << 4));
   assign p3 = p2 & ((p2 << 4) | 16'h000F);
   assign g4 = g3 | (p3 & (g3 << 8));

   // g4[i] is the carry out of bit i.
   assign S = {g4[15], p0 ^ {g4[14:0], 1'b0}};
endmodule

module ks_accum_16 #(
   parameter int BLOCK_LEN = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_sum,
   output logic        out_ovf,
   output logic [8:0]  out_count
);
   typedef enum logic {ST_ACC = 1'b0, ST_OUT = 1'b1} state_t;

   localparam logic [8:0] BLK = BLOCK_LEN[8:0];

   state_t      state, state_nxt;
   logic [15:0] acc;
   logic        ovf;
   logic [8:0]  cnt;
   logic [16:0] s;
   logic [15:0] acc_next;
   logic [8:0]  cnt_inc;
   logic        ovf_next;
   logic        accept;
   logic        close_blk;

   kogge_stone_16bit u_add (
      .Ai (acc),
      .Bi (in_data),
      .S  (s)
   );

   assign accept    = in_valid && (state == ST_ACC) && !clear;
   assign cnt_inc   = cnt + 9'd1;
   assign close_blk = in_last || (cnt_inc == BLK);
   assign ovf_next  = ovf | s[16];

`ifdef KS_ACCUM_SATURATE_EN
   assign acc_next = s[16] ? 16'hFFFF : s[15:0];
`else
   assign acc_next = s[15:0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_ACC;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_ACC: begin
            in_ready = 1'b1;
            if (accept && close_blk) begin
               state_nxt = ST_OUT;
            end
         end
         ST_OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = ST_ACC;
            end
         end
         default: state_nxt = ST_ACC;
      endcase
      if (clear) begin
         state_nxt = ST_ACC;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= 16'd0;
         ovf       <= 1'b0;
         cnt       <= 9'd0;
         out_sum   <= 16'd0;
         out_ovf   <= 1'b0;
         out_count <= 9'd0;
      end else if (clear) begin
         acc <= 16'd0;
         ovf <= 1'b0;
         cnt <= 9'd0;
      end else if (accept) begin
         acc <= acc_next;
         ovf <= ovf_next;
         cnt <= cnt_inc;
         if (close_blk) begin
            out_sum   <= acc_next;
            out_ovf   <= ovf_next;
            out_count <= cnt_inc;
         end
      end else if ((state == ST_OUT) && out_ready) begin
         acc <= 16'd0;
         ovf <= 1'b0;
         cnt <= 9'd0;
      end
   end
endmodule

// File: tb/tb_ks_accum_16.sv
// tb/tb_ks_accum_16.sv - scoreboard bench for ks_accum_16 (BLOCK_LEN 8 and 1)
module tb_ks_accum_16;
   typedef logic [25:0] exp_t;   // {sum, ovf, count}

`ifdef KS_ACCUM_SATURATE_EN
   localparam logic [15:0] EXP_8000_8001 = 16'hFFFF;
   localparam logic [15:0] EXP_FFFF_X4   = 16'hFFFF;
`else
   localparam logic [15:0] EXP_8000_8001 = 16'h0001;
   localparam logic [15:0] EXP_FFFF_X4   = 16'hFFFC;
`endif

   logic        clk;
   logic        rst_n;
   logic        clear, in_valid, in_last, out_ready;
   logic [15:0] in_data;
   logic        in_ready, out_valid, out_ovf;
   logic [15:0] out_sum;
   logic [8:0]  out_count;

   logic        clear1, in_valid1, in_last1, out_ready1;
   logic [15:0] in_data1;
   logic        in_ready1, out_valid1, out_ovf1;
   logic [15:0] out_sum1;
   logic [8:0]  out_count1;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t q8[$];
   exp_t q1[$];

   ks_accum_16 #(.BLOCK_LEN(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_ovf(out_ovf), .out_count(out_count)
   );

   ks_accum_16 #(.BLOCK_LEN(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .clear(clear1), .in_valid(in_valid1),
      .in_ready(in_ready1), .in_data(in_data1), .in_last(in_last1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
      .out_ovf(out_ovf1), .out_count(out_count1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic send8(input logic [15:0] d, input logic last);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n >= 50) begin
         failures++;
         $display("FAIL send8_timeout actual=%0d expected=<50", n);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (q8.size() == 0) begin
            checks++; failures++;
            $display("FAIL mon8_unexpected actual=%0h expected=none", {out_sum, out_ovf, out_count});
         end else begin
            chk("mon8_result", {6'd0, out_sum, out_ovf, out_count}, {6'd0, q8.pop_front()});
         end
      end
      if (rst_n && out_valid1 && out_ready1) begin
         if (q1.size() == 0) begin
            checks++; failures++;
            $display("FAIL mon1_unexpected actual=%0h expected=none", {out_sum1, out_ovf1, out_count1});
         end else begin
            chk("mon1_result", {6'd0, out_sum1, out_ovf1, out_count1}, {6'd0, q1.pop_front()});
         end
      end
   end

   initial begin
      logic [15:0] vals [0:5];
      int prev_cyc;
      int n;
      vals[0] = 16'h1234; vals[1] = 16'hFFFF; vals[2] = 16'h0000;
      vals[3] = 16'h8001; vals[4] = 16'h00A5; vals[5] = 16'h7FFE;

      rst_n = 1'b0;
      clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 16'd0; out_ready = 1'b1;
      clear1 = 1'b0; in_valid1 = 1'b0; in_last1 = 1'b0; in_data1 = 16'd0; out_ready1 = 1'b1;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_ovf", out_ovf, 0);
      chk("rst_out_count", out_count, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1..8 back-to-back, full block closes on count
      for (int v = 1; v <= 8; v++) begin
         if (v == 8) q8.push_back({16'd36, 1'b0, 9'd8});
         send8(v[15:0], 1'b0);
      end
      chk("blk8_out_valid_hi", out_valid, 1);
      chk("blk8_in_ready_lo", in_ready, 0);
      @(posedge clk); #1;
      chk("blk8_out_valid_1cyc", out_valid, 0);
      chk("blk8_in_ready_back", in_ready, 1);

      // carry out of bit 15
      q8.push_back({EXP_8000_8001, 1'b1, 9'd2});
      send8(16'h8000, 1'b0);
      send8(16'h8001, 1'b1);
      @(posedge clk); #1;

      // backpressure: result held, extra samples not consumed
      out_ready = 1'b0;
      q8.push_back({16'd18, 1'b0, 9'd3});
      send8(16'd5, 1'b0);
      send8(16'd6, 1'b0);
      send8(16'd7, 1'b1);
      in_valid = 1'b1; in_data = 16'd99;
      for (int k = 0; k < 4; k++) begin
         chk("stall_out_valid", out_valid, 1);
         chk("stall_out_sum", out_sum, 18);
         chk("stall_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      q8.push_back({16'd3, 1'b0, 9'd2});
      send8(16'd1, 1'b0);
      send8(16'd2, 1'b1);
      @(posedge clk); #1;

      // clear mid-block; the sample alongside clear is dropped
      send8(16'd100, 1'b0);
      send8(16'd100, 1'b0);
      send8(16'd100, 1'b0);
      clear = 1'b1; in_valid = 1'b1; in_data = 16'd500;
      @(posedge clk); #1;
      clear = 1'b0; in_valid = 1'b0;
      q8.push_back({16'd20, 1'b0, 9'd2});
      send8(16'd10, 1'b0);
      send8(16'd10, 1'b1);
      @(posedge clk); #1;

      // asynchronous reset mid-block
      send8(16'd1, 1'b0);
      send8(16'd2, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_blk_in_ready", in_ready, 1);
      chk("arst_blk_out_sum", out_sum, 0);
      chk("arst_blk_out_count", out_count, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // asynchronous reset while holding a result
      out_ready = 1'b0;
      send8(16'd7, 1'b1);
      chk("arst_out_pre_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_out_in_ready", in_ready, 1);
      chk("arst_out_sum", out_sum, 0);
      chk("arst_out_ovf", out_ovf, 0);
      chk("arst_out_count", out_count, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      q8.push_back({EXP_FFFF_X4, 1'b1, 9'd4});
      send8(16'hFFFF, 1'b0);
      send8(16'hFFFF, 1'b0);
      send8(16'hFFFF, 1'b0);
      send8(16'hFFFF, 1'b1);
      @(posedge clk); #1;

      // BLOCK_LEN = 1 streaming, one accept every 2 cycles
      in_valid1 = 1'b1;
      prev_cyc = 0;
      for (int k = 0; k < 6; k++) begin
         in_data1 = vals[k];
         q1.push_back({vals[k], 1'b0, 9'd1});
         n = 0;
         while (!in_ready1 && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         checks++;
         if (n >= 20) begin
            failures++;
            $display("FAIL send1_timeout actual=%0d expected=<20", n);
         end
         @(posedge clk); #1;
         if (k > 0) chk("bl1_accept_gap", cyc - prev_cyc, 2);
         prev_cyc = cyc;
      end
      in_valid1 = 1'b0;

      repeat (5) @(posedge clk);
      #1;
      chk("q8_drained", q8.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ks_accum_16.md
# ks_accum_16

Streaming 16-bit unsigned accumulator that sits directly downstream of `kogge_stone_16bit`. It instantiates the adder with `Ai` driven by the running sum and `Bi` driven by the incoming sample. Each cycle it registers the adder's 17-bit result `S` back into the accumulator. Samples are grouped into blocks, and each completed block sum is presented on a valid/ready output port together with a sticky overflow flag and the sample count.

## Interface

Parameters:
- `BLOCK_LEN`, default 8: maximum number of samples per block; legal range 1..256.

Ports:
- `clk`, input, 1: the single clock; all state is on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `clear`, input, 1: synchronous abort; discards the current block and returns to ACC.
- `in_valid`, input, 1: a sample is present on `in_data`.
- `in_ready`, output, 1: the block can accept a sample this cycle.
- `in_data`, input, 16: unsigned sample; drives adder `Bi`.
- `in_last`, input, 1: this sample closes the block early; qualified by `in_valid`.
- `out_valid`, output, 1: a block result is held on the output port.
- `out_ready`, input, 1: the consumer accepts the result.
- `out_sum`, output, 16: block sum.
- `out_ovf`, output, 1: sticky flag; `S[16]` was set on at least one add in the block.
- `out_count`, output, 9: number of samples in the block, 1..`BLOCK_LEN`.

## Operation

The block has two states.

- **ACC** (reset state):
  - `in_ready` = 1.
  - Accept occurs when `in_valid && in_ready`.
  - On accept: `acc` <= `S[15:0]`; `ovf` <= `ovf | S[16]`; `cnt` <= `cnt` + 1.
  - If `in_last` = 1, or `cnt + 1 == BLOCK_LEN`, go to OUT. The output registers take the updated `acc`, `ovf` and `cnt + 1`.
- **OUT**:
  - `in_ready` = 0; `out_valid` = 1.
  - Output registers hold stable until handshake.
  - On `out_valid && out_ready`: `acc`, `ovf` and `cnt` go to 0, and the state returns to ACC.

Adder connection:
- Adder `Ai` = `acc`, `Bi` = `in_data`.
- The adder is purely combinational; no extra pipeline stage is added, so one sample is accepted per cycle.

Arithmetic:
- Unsigned arithmetic throughout.
- Without saturation, the sum wraps modulo 2^16 and `out_ovf` records that a wrap occurred.

`clear` behaviour:
- `clear` = 1 in either state: `acc`, `ovf` and `cnt` go to 0; `out_valid` = 0; next state is ACC.
- A sample presented in the same cycle as `clear` is dropped.
- `clear` has priority over both the input and output handshakes.

Other boundary conditions:
- `in_last` with `in_valid` = 0 is ignored.
- `BLOCK_LEN` = 1: every accepted sample closes a block, and `out_sum` equals that sample.
- `cnt` never exceeds `BLOCK_LEN`; `out_count` = 256 is representable.
- No sample is accepted while in OUT, so there is no overlap between blocks.

## Timing

- Reset values: `in_ready` = 1, `out_valid` = 0, `out_sum` = 0, `out_ovf` = 0, `out_count` = 0; internal `acc`, `ovf` and `cnt` = 0; state = ACC.
- Latency: `out_valid` rises on the cycle after the closing sample is accepted.
- Throughput: one dead cycle between blocks, since `in_ready` returns to 1 on the cycle after the output handshake. The sustained rate is N samples per N+1 cycles when `out_ready` is held at 1.
- Output handshake: `out_sum`, `out_ovf` and `out_count` are registered and stable while `out_valid` = 1. Driving `out_ready` while `out_valid` = 0 has no effect.
- `in_ready` is a registered state decode, with no combinational path from `out_ready`.
- Asynchronous reset mid-block or in OUT: all outputs return to their reset values immediately, and the partial block is lost.

## Configuration

- Macro: `KS_ACCUM_SATURATE_EN`.
- Defined: on any accept where `S[16]` = 1, `acc` <= 16'hFFFF instead of `S[15:0]`, and `ovf` is set. Once saturated, `acc` stays at 16'hFFFF for the rest of the block, because every further add produces a carry or an exact 16'hFFFF.
- Undefined: wrap-around behaviour as described in Operation. `ovf` is identical in both builds.

## Test plan

- Reset, then `BLOCK_LEN` = 8 and samples 1..8 back-to-back with `out_ready` = 1 -> `out_sum` = 36, `out_count` = 8, `out_ovf` = 0. `out_valid` is high for 1 cycle, one cycle after the 8th accept, and `in_ready` is 0 in that cycle.
- Samples 16'h8000, 16'h8001 with `in_last` on the second -> wrap build: `out_sum` = 16'h0001, `out_ovf` = 1, `out_count` = 2. Saturate build: `out_sum` = 16'hFFFF, `out_ovf` = 1.
- Block of 3 samples (5, 6, 7) with `in_last` on 7, `out_ready` held 0 for 4 cycles -> `out_valid` stays 1 with `out_sum` = 18 stable, `in_ready` = 0, extra `in_valid` samples are not consumed. The next block starts with `acc` = 0.
- `clear` asserted after 3 samples (value 100 each), then 2 samples of 10 with `in_last` -> `out_sum` = 20, `out_count` = 2.
- `rst_n` pulled low asynchronously mid-block and while in OUT -> outputs are at their reset values before the next clock edge; after release, a block of 4 samples of 16'hFFFF gives wrap build `out_sum` = 16'hFFFC with `out_ovf` = 1.
- `BLOCK_LEN` = 1, random 16-bit samples streaming -> each `out_sum` equals its sample, `out_count` = 1, and one accept occurs every 2 cycles.
